// File: rtl/token_pkg.sv
// Shared types and constants for the token merge block.
package token_pkg;

  localparam int PEND_W_DEFAULT = 4;
  localparam int DROP_CNT_W     = 8;

  // Per-cycle token count: 0, 1 or 2.
  typedef logic [1:0] tok_cnt_t;

  function automatic tok_cnt_t tok_count(input logic x, input logic y);
    return {1'b0, x} + {1'b0, y};
  endfunction

endpackage

// File: rtl/token_pend_cnt.sv
// Saturating next-value calculation for the pending-token counter.
// Reports how many tokens fell off the top when the count clips at MAX.
module token_pend_cnt
  import token_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEFAULT
) (
  input  logic [PEND_W-1:0] cur_i,
  input  tok_cnt_t          inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] count_o,
  output tok_cnt_t          drop_o
);

  localparam logic [PEND_W+1:0] MAX_EXT = {2'b00, {PEND_W{1'b1}}};

  logic [PEND_W+1:0] avail_s;
  logic [PEND_W+1:0] raw_s;

  // Add arrivals at full width, subtract emission, then clip at MAX.
  always_comb begin
    avail_s = {2'b00, cur_i} + {{PEND_W{1'b0}}, inc_i};
    raw_s   = avail_s - {{(PEND_W+1){1'b0}}, dec_i};
    if (raw_s > MAX_EXT) begin
      count_o = {PEND_W{1'b1}};
      drop_o  = tok_cnt_t'(raw_s - MAX_EXT);
    end else begin
      count_o = raw_s[PEND_W-1:0];
      drop_o  = 2'b00;
    end
  end

endmodule

// File: rtl/token_merge.sv
// Merges two token streams into one registered stream, buffering excess tokens.
// Optional drop counter output enabled by macro TOKEN_MERGE_DROP_CNT_EN.
module token_merge
  import token_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a,
  input  logic              c,
  input  logic              en,
  input  logic              clr_ovf,
  output logic              b,
  output logic [PEND_W-1:0] pend,
  output logic              full,
`ifdef TOKEN_MERGE_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
  output logic              ovf
);

  logic              b_q, b_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  tok_cnt_t          inc_s;
  tok_cnt_t          drop_s;
  logic              avail_nz_s;
  logic              dec_s;

  assign inc_s      = tok_count(a, c);
  assign avail_nz_s = (pend_q != {PEND_W{1'b0}}) | a | c;
  assign dec_s      = en & avail_nz_s;

  token_pend_cnt #(.PEND_W(PEND_W)) u_pend_cnt (
    .cur_i   (pend_q),
    .inc_i   (inc_s),
    .dec_i   (dec_s),
    .count_o (pend_d),
    .drop_o  (drop_s)
  );

  // Emission and sticky overflow; a fresh drop beats a same-cycle clear.
  always_comb begin
    b_d   = dec_s;
    ovf_d = ovf_q;
    if (drop_s != 2'b00) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Output and counter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_q    <= 1'b0;
      pend_q <= {PEND_W{1'b0}};
      ovf_q  <= 1'b0;
    end else begin
      b_q    <= b_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign b    = b_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;
  assign full = (pend_q == {PEND_W{1'b1}});

`ifdef TOKEN_MERGE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   drop_sum_s;

  // Saturating accumulation; clear reloads with this cycle's drop amount.
  always_comb begin
    drop_sum_s = {1'b0, drop_cnt_q} + {{(DROP_CNT_W-1){1'b0}}, drop_s};
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      drop_cnt_d = {{(DROP_CNT_W-2){1'b0}}, drop_s};
    end else if (drop_sum_s[DROP_CNT_W]) begin
      drop_cnt_d = {DROP_CNT_W{1'b1}};
    end else begin
      drop_cnt_d = drop_sum_s[DROP_CNT_W-1:0];
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= {DROP_CNT_W{1'b0}};
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_token_merge.sv
// Directed bench for token_merge: vector table plus multi-cycle corner sequences.
module tb_token_merge;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, c, en, clr_ovf;
  logic       b, full, ovf;
  logic [3:0] pend;
`ifdef TOKEN_MERGE_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  token_merge #(.PEND_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .c       (c),
    .en      (en),
    .clr_ovf (clr_ovf),
    .b       (b),
    .pend    (pend),
    .full    (full),
`ifdef TOKEN_MERGE_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .ovf     (ovf)
  );

  typedef struct {
    logic       rst, a, c, en, clr;
    logic       eb;
    logic [3:0] ep;
    logic       ef, eo;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs after the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic ia, input logic ic, input logic ie, input logic icl);
    @(negedge clk);
    rst = r; a = ia; c = ic; en = ie; clr_ovf = icl;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, ia, ic, ie, icl, eb, input logic [3:0] ep,
                              input logic ef, eo);
    vec_t v;
    v.rst = r; v.a = ia; v.c = ic; v.en = ie; v.clr = icl;
    v.eb = eb; v.ep = ep; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  int nb, nin, ndrop, mp, avail, nxt, mdrop, exp_b;
  logic m_ovf;
  logic ra, rc, re;

  initial begin
    rst = 1'b0; a = 1'b1; c = 1'b1; en = 1'b1; clr_ovf = 1'b0;

    // rst a c en clr | b pend full ovf
    vt[0]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    vt[2]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    vt[3]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    vt[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    vt[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    vt[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    vt[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    vt[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    vt[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    vt[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    vt[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    vt[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    vt[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    vt[14] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    vt[15] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    vt[16] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      step(vt[i].rst, vt[i].a, vt[i].c, vt[i].en, vt[i].clr);
      check($sformatf("vec%0d_b", i),    int'(b),    int'(vt[i].eb));
      check($sformatf("vec%0d_pend", i), int'(pend), int'(vt[i].ep));
      check($sformatf("vec%0d_full", i), int'(full), int'(vt[i].ef));
      check($sformatf("vec%0d_ovf", i),  int'(ovf),  int'(vt[i].eo));
    end

    // Stall overflow: 16 tokens into a 15-deep counter.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("stall_pend", int'(pend), (2 * k > 15) ? 15 : 2 * k);
      check("stall_ovf",  int'(ovf),  (k == 8) ? 1 : 0);
    end
    check("stall_full", int'(full), 1);
`ifdef TOKEN_MERGE_DROP_CNT_EN
    check("stall_drop_cnt", int'(drop_cnt), 1);
`endif

    // Clear racing a drop: the drop wins.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("race_ovf", int'(ovf), 1);
`ifdef TOKEN_MERGE_DROP_CNT_EN
    check("race_drop_cnt", int'(drop_cnt), 1);
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clear_ovf", int'(ovf), 0);
    check("clear_pend", int'(pend), 15);
`ifdef TOKEN_MERGE_DROP_CNT_EN
    check("clear_drop_cnt", int'(drop_cnt), 0);
`endif

    // Drain: exactly 15 pulses within a bounded window.
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      nb += int'(b);
    end
    check("drain_pulses", nb, 15);
    check("drain_pend", int'(pend), 0);

    // Dual burst: 20 consecutive pulses, pend ramps to 10 and back.
    for (int k = 1; k <= 20; k++) begin
      if (k <= 10) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      else         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("burst_b",    int'(b),    1);
      check("burst_pend", int'(pend), (k <= 10) ? k : 20 - k);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("burst_end_b", int'(b), 0);
    check("burst_ovf",   int'(ovf), 0);

    // Single stream: b follows a one cycle later.
    for (int k = 0; k < 50; k++) begin
      ra = 1'($urandom_range(1, 0));
      step(1'b1, ra, 1'b0, 1'b1, 1'b0);
      check("single_b",    int'(b),    int'(ra));
      check("single_pend", int'(pend), 0);
    end

    // Random traffic against a token-accounting model, then idle drain.
    mp = 0; nb = 0; nin = 0; ndrop = 0; m_ovf = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k < 100) begin
        ra = 1'($urandom_range(1, 0));
        rc = 1'($urandom_range(1, 0));
        re = 1'($urandom_range(1, 0));
      end else begin
        ra = 1'b0; rc = 1'b0; re = 1'b1;
      end
      avail = mp + int'(ra) + int'(rc);
      exp_b = (re && avail != 0) ? 1 : 0;
      nxt   = avail - exp_b;
      mdrop = (nxt > 15) ? nxt - 15 : 0;
      mp    = (nxt > 15) ? 15 : nxt;
      nin  += int'(ra) + int'(rc);
      ndrop += mdrop;
      if (mdrop != 0) m_ovf = 1'b1;
      step(1'b1, ra, rc, re, 1'b0);
      nb += int'(b);
      check("rand_b",    int'(b),    exp_b);
      check("rand_pend", int'(pend), mp);
    end
    check("rand_conserve", nb + ndrop, nin);
    check("rand_final_pend", int'(pend), 0);
    check("rand_ovf", int'(ovf), int'(m_ovf));
`ifdef TOKEN_MERGE_DROP_CNT_EN
    check("rand_drop_cnt", int'(drop_cnt), (ndrop > 255) ? 255 : ndrop);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/token_merge.md
TOKEN_MERGE -- requirements
Module: token_merge

Interface
REQ-001 Parameter PEND_W, default 4: pending-counter width; MAX = 2^PEND_W-1 (15 at default).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 a  input  1  token stream 0; high = one token this cycle.
REQ-005 c  input  1  token stream 1; high = one token this cycle.
REQ-006 en  input  1  downstream enable; low = stall output, accumulate tokens.
REQ-007 clr_ovf  input  1  synchronous clear of sticky overflow flag.
REQ-008 b  output  1  merged token stream, registered; feeds the halving stage downstream.
REQ-009 pend  output  PEND_W  registered count of tokens accepted but not yet emitted.
REQ-010 full  output  1  combinational, pend == MAX.
REQ-011 ovf  output  1  sticky flag; set when any token is dropped.

Function
REQ-012 Each cycle: avail = pend + a + c (range 0..MAX+2), computed at PEND_W+2 bits, no truncation.
REQ-013 With en=1: b <= (avail != 0); pend <= min(avail - (avail != 0), MAX).
REQ-014 With en=0: b <= 0; pend <= min(avail, MAX).
REQ-015 Dropped tokens per cycle = pre-saturation next-pend minus MAX when positive (0, 1 or 2); any drop sets ovf next edge.
REQ-016 Latency: a token arriving at pend=0 with en=1 appears on b exactly one cycle later; at most one token is emitted per cycle.
REQ-017 Ordering is irrelevant (tokens are unlabelled); a and c both high counts as two tokens.
REQ-018 Conservation invariant at every edge: total tokens in == total tokens emitted + pend + total dropped.
REQ-019 clr_ovf=1 clears ovf next edge unless a drop occurs the same cycle; the new drop wins and ovf stays 1.
REQ-020 en toggling mid-drain: emission resumes the cycle after en returns high, with no loss or duplication.

Reset
REQ-021 rst low asynchronously forces b=0, pend=0, ovf=0 (full=0 follows); the drop counter, when compiled in, also resets to 0.
REQ-022 Tokens present on a/c while rst is low are discarded and are not counted.
REQ-023 Reset asserted mid-drain discards all pending tokens; first emission after release requires a new input token.

Configuration
REQ-024 Macro TOKEN_MERGE_DROP_CNT_EN: when defined, adds output drop_cnt (8 bits, registered, saturating at 255) accumulating dropped tokens (+1 or +2 per cycle).
REQ-025 clr_ovf also zeroes drop_cnt, with the same-cycle-drop rule: drop_cnt loads the new drop amount.
REQ-026 Macro not defined: drop_cnt port and logic are absent; all other behaviour is identical.

Structure
REQ-027 Shared package token_pkg holds PEND_W_DEFAULT=4, DROP_CNT_W=8, and a typedef for the 2-bit per-cycle token count.
REQ-028 Saturating add/sub of pend lives in sub-module token_pend_cnt (inputs: inc 0..2, dec 0..1; outputs: count, drop 0..2); token_merge instantiates it once.

Verification
REQ-029 Reset: rst=0 with a=c=1, en=1 -> b=0, pend=0, full=0, ovf=0 throughout; after release with a=c=0, b stays 0.
REQ-030 Dual burst: en=1, a=c=1 for 10 cycles then idle -> b high for 20 consecutive cycles starting 1 cycle after the first input; pend peaks at 10, returns to 0; ovf=0.
REQ-031 Single stream: a=1, c=0, en=1 for 50 random cycles -> b equals a delayed one cycle; pend stays 0.
REQ-032 Stall overflow (PEND_W=4): en=0, a=c=1 for 8 cycles -> pend=15, full=1, ovf=1, 1 token dropped (drop_cnt=1 if enabled); then en=1, a=c=0 -> exactly 15 b pulses, then pend=0.
REQ-033 Clear race: clr_ovf=1 in a cycle with a drop -> ovf stays 1; clr_ovf=1 alone next cycle -> ovf=0, drop_cnt=0.
REQ-034 Random: 100 cycles random a, c, en, then en=1 idle for 200 cycles -> count(b) + drops == count(a) + count(c); final pend=0.
